// File: rtl/video_timing_gen_pkg.sv
// Shared raster timing constants and types for the DVI timing generator.
// Presets hold active/porch/sync lengths per axis plus the common sync polarity.
package video_timing_gen_pkg;

  typedef enum logic {
    SyncNeg = 1'b0,
    SyncPos = 1'b1
  } sync_pol_e;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    sync_pol_e    pol;
  } video_timing_t;

  localparam video_timing_t VGA_640x480 = '{
    h:   '{active: 640, fp: 16, sync: 96, bp: 48},
    v:   '{active: 480, fp: 10, sync: 2, bp: 33},
    pol: SyncNeg
  };

  localparam video_timing_t HD_1280x720 = '{
    h:   '{active: 1280, fp: 110, sync: 40, bp: 220},
    v:   '{active: 720, fp: 5, sync: 5, bp: 20},
    pol: SyncPos
  };

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster dimension: position counter plus blank/sync/start flags.
// Flags describe the position the counter moves to on this edge, so a parent register aligns them.
module timing_axis
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter sync_pol_e   POL    = SyncNeg,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] pos,
  output logic         wrap,
  output logic         blank,
  output logic         sync,
  output logic         start
);

  localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_BEGIN = ACTIVE + FP;
  localparam int unsigned SYNC_END   = ACTIVE + FP + SYNC;
  localparam logic [W-1:0] LAST      = W'(TOTAL - 1);

  logic [W-1:0] pos_q, pos_d;
  logic [31:0]  pos_ext;
  logic         sync_act;

  assign pos  = pos_q;
  assign wrap = (pos_q == LAST);

  always_comb begin
    pos_d = pos_q;
    if (step) begin
      pos_d = wrap ? '0 : pos_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  // A zero SYNC makes the window empty, so sync never asserts.
  always_comb begin
    pos_ext  = 32'(pos_d);
    blank    = (pos_ext >= ACTIVE);
    sync_act = (pos_ext >= SYNC_BEGIN) && (pos_ext < SYNC_END);
    sync     = (POL == SyncPos) ? sync_act : ~sync_act;
    start    = (pos_d == '0);
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator feeding the TMDS encoder: blanking, hsync (c0), vsync (c1), coordinates.
// Two timing_axis counters; all flags registered here so they match x/y in the same cycle.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640x480.h.active,
  parameter int unsigned H_FP     = VGA_640x480.h.fp,
  parameter int unsigned H_SYNC   = VGA_640x480.h.sync,
  parameter int unsigned H_BP     = VGA_640x480.h.bp,
  parameter int unsigned V_ACTIVE = VGA_640x480.v.active,
  parameter int unsigned V_FP     = VGA_640x480.v.fp,
  parameter int unsigned V_SYNC   = VGA_640x480.v.sync,
  parameter int unsigned V_BP     = VGA_640x480.v.bp,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           blanking,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start
);

  localparam sync_pol_e POL = sync_pol_e'(SYNC_POL);

  logic h_wrap, h_blank, h_sync, h_start;
  logic v_wrap, v_blank, v_sync, v_start;
  logic v_step;
  logic unused_v_wrap;

  logic blanking_q, blanking_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  assign v_step        = ce & h_wrap;
  assign unused_v_wrap = v_wrap;

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (POL),
    .W      (X_W)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (ce),
    .pos   (x),
    .wrap  (h_wrap),
    .blank (h_blank),
    .sync  (h_sync),
    .start (h_start)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (POL),
    .W      (Y_W)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (v_step),
    .pos   (y),
    .wrap  (v_wrap),
    .blank (v_blank),
    .sync  (v_sync),
    .start (v_start)
  );

  // Axis flags already reflect the held position when ce is low, so no enable is needed here.
  always_comb begin
    blanking_d    = h_blank | v_blank;
    hsync_d       = h_sync;
    vsync_d       = v_sync;
    line_start_d  = h_start;
    frame_start_d = h_start & v_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blanking_q    <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      blanking_q    <= blanking_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign blanking    = blanking_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator that drives the TMDS encoder stage directly upstream of it in the DVI path.
- Scans the pixel grid one pixel per enabled clock.
- Produces the encoder's control inputs: blanking, plus hsync/vsync, which map to c0/c1 on the blue channel.
- Produces the pixel coordinates the framebuffer/pattern source uses to produce din.
- Defaults are 640x480@60 (25 MHz pixel clock).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)
X_W, 10, width of x counter; must hold H_TOTAL-1
Y_W, 10, width of y counter; must hold V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous, active-low reset
ce  in  1  pixel clock enable; position advances only when high
x  out  X_W  current horizontal position, 0..H_TOTAL-1
y  out  Y_W  current line, 0..V_TOTAL-1
blanking  out  1  high outside the active area; feeds the encoder's blanking input
hsync  out  1  horizontal sync at SYNC_POL level; feeds the encoder's c0
vsync  out  1  vertical sync at SYNC_POL level; feeds the encoder's c1
line_start  out  1  high while x==0
frame_start  out  1  high while x==0 and y==0

Behaviour:
- Definitions: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (rst_n low, asynchronous) sets:
  - x=0, y=0, blanking=0
  - hsync=vsync=~SYNC_POL (deasserted)
  - line_start=1, frame_start=1
  - Together these present pixel (0,0).
- All outputs are registered, and all describe the same position in the same cycle.
- No combinational path from ce to any output.
- Advance rule: on a rising clk with ce=1:
  - x increments.
  - If x==H_TOTAL-1: x wraps to 0 and y increments.
  - If additionally y==V_TOTAL-1: y wraps to 0.
- With ce=0 every output holds its value.
- blanking = (x >= H_ACTIVE) or (y >= V_ACTIVE).
- hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
- vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491), for every x on those lines.
- Flags are computed from the next-position value so they update in the same edge as x/y. The latency from position change to flag change is 0 cycles.
- line_start and frame_start are levels tied to position. With ce tied high they are one-cycle pulses every H_TOTAL and H_TOTAL*V_TOTAL cycles respectively.
- Frame length is exactly H_TOTAL*V_TOTAL enabled cycles (420000). No dropped or duplicated pixel at either wrap.
- Simultaneous wraps: x wrap and y wrap on the same edge produce (0,0) with frame_start=1, vsync deasserted and blanking=0.
- Reset mid-frame: returns to (0,0) immediately (asynchronously), regardless of ce. Release is synchronous to clk; the first advance happens on the first ce edge after release.
- Degenerate parameters (any porch or sync = 0) must still produce correct totals. Zero-width sync means that sync output is never asserted.

Decomposition:
- Shared package holds the timing constants:
  - VGA_640x480: 640/16/96/48, 480/10/2/33, neg/neg
  - HD_1280x720: 1280/110/40/220, 720/5/5/20, pos/pos
  - a sync-polarity enum
- One sub-module: timing_axis, a single-dimension counter with parameters ACTIVE/FP/SYNC/BP/POL. It has inputs step and an outputs bundle (pos, wrap, blank, sync, start).
  - Instantiated twice.
  - Horizontal instance steps on ce.
  - Vertical instance steps on ce & horizontal wrap.
  - Top level ORs the two blanks and registers/aligns the outputs.

Test Plan:
- Reset: hold rst_n=0 for 3 clk with ce=1 -> x=0, y=0, blanking=0, hsync=vsync=1, frame_start=1. Release, then 1 ce edge -> x=1, frame_start=0, line_start=0.
- Horizontal timing, ce=1, defaults:
  - blanking rises at x=640
  - hsync=0 for exactly x=656..751 (96 cycles)
  - line_start=1 at x=0 every 800 cycles
- Vertical timing: run a full frame -> vsync=0 exactly on y=490..491 (1600 cycles), blanking=1 for all of y>=480, frame_start period = 420000 cycles.
- Wrap: from x=799, y=524, 1 ce edge -> x=0, y=0, frame_start=1, blanking=0, vsync=1.
- ce gating: toggle ce 1/0 every cycle -> each position held exactly 2 clocks, frame takes 840000 clocks, outputs constant while ce=0.
- Mid-frame reset: assert rst_n=0 at x=700, y=490 (hsync and vsync both asserted) -> outputs return to reset values asynchronously, before the next clk edge.
- Alternate parameter set HD_1280x720, SYNC_POL=1 -> hsync=1 on x=1390..1429, frame = 1650*750 cycles.
